sap_alu_stage: RTL and testbench

Operand-B register, add/subtract datapath and flags register for the SAP-U 8-bit datapath. Takes the accumulator value and a bus-loaded B operand and forms A+B or A−B through two cascaded 4-bit carry-lookahead adders. It drives the result onto the system bus under control-word enable and latches carry, zero and overflow flags for conditional jumps. It sits between the bus/accumulator and the control sequencer's flag inputs.

---
 rtl/sap_pkg.sv | 14 +
 rtl/dm74ls283_quad_adder.sv | 30 +++
 rtl/sap_alu_stage.sv | 113 +++++++++++
 tb/tb_sap_alu_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared SAP-U definitions: datapath width and control-word bit positions.
package sap_pkg;

  localparam int SAP_WIDTH = 8;

  // Bit positions of the ALU-stage controls inside the sequencer control word.
  localparam int BI = 0;  // load B register from bus
  localparam int SU = 1;  // subtract select
  localparam int EO = 2;  // drive sum onto bus
  localparam int FI = 3;  // latch flags

  localparam int CW_BITS = 4;

endpackage

// File: rtl/dm74ls283_quad_adder.sv
// 4-bit carry-lookahead adder slice, modelled on the 74LS283.
module dm74ls283_quad_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flat lookahead equations: every carry depends only on g, p and cin.
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/sap_alu_stage.sv
// SAP-U ALU stage: B register, add/subtract through chained 4-bit adders,
// bus driver and latched carry/zero/overflow flags.
module sap_alu_stage
  import sap_pkg::*;
#(
  parameter int WIDTH = SAP_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic             bi,
  input  logic             su,
  input  logic             eo,
  input  logic             fi,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic [WIDTH-1:0] b_reg,
  output logic             cf,
  output logic             zf,
  output logic             of,
  output logic             bus_conflict
);

  localparam int NIBBLES = WIDTH / 4;

  logic [CW_BITS-1:0] cw;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cf_q, cf_d;
  logic               zf_q, zf_d;
  logic               of_q, of_d;
  logic               conflict_q, conflict_d;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   sum;
  logic [NIBBLES:0]   carry_chain;
  logic               carry;
  logic               ovf;

  // Gather controls in sequencer control-word order so decode matches it.
  always_comb begin
    cw     = '0;
    cw[BI] = bi;
    cw[SU] = su;
    cw[EO] = eo;
    cw[FI] = fi;
  end

  // Subtraction is A + ~B + 1: invert B and feed su in as carry.
  assign b_eff          = b_q ^ {WIDTH{cw[SU]}};
  assign carry_chain[0] = cw[SU];

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nibble
      dm74ls283_quad_adder u_adder (
        .a    (a_in[gi*4 +: 4]),
        .b    (b_eff[gi*4 +: 4]),
        .cin  (carry_chain[gi]),
        .sum  (sum[gi*4 +: 4]),
        .cout (carry_chain[gi+1])
      );
    end
  endgenerate

  assign carry = carry_chain[NIBBLES];
  assign ovf   = (a_in[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);

  // Next-state for B, flags and the sticky conflict bit. A load is refused
  // while we drive the bus, since B would otherwise capture its own result.
  always_comb begin
    b_d        = b_q;
    cf_d       = cf_q;
    zf_d       = zf_q;
    of_d       = of_q;
    conflict_d = conflict_q;
    if (cw[BI] && !cw[EO]) begin
      b_d = bus_in;
    end
    if (cw[FI]) begin
      cf_d = carry;
      zf_d = (sum == '0);
      of_d = ovf;
    end
    if (cw[BI] && cw[EO]) begin
      conflict_d = 1'b1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q        <= '0;
      cf_q       <= 1'b0;
      zf_q       <= 1'b0;
      of_q       <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      b_q        <= b_d;
      cf_q       <= cf_d;
      zf_q       <= zf_d;
      of_q       <= of_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus_oe       = cw[EO];
  assign bus_out      = cw[EO] ? sum : '0;
  assign b_reg        = b_q;
  assign cf           = cf_q;
  assign zf           = zf_q;
  assign of           = of_q;
  assign bus_conflict = conflict_q;

endmodule

// File: tb/tb_sap_alu_stage.sv
// Directed bench for sap_alu_stage: one task per scenario, hand-computed expectations.
module tb_sap_alu_stage;

  logic       clk;
  logic       rst_n;
  logic [7:0] bus_in;
  logic [7:0] a_in;
  logic       bi, su, eo, fi;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] b_reg;
  logic       cf, zf, of;
  logic       bus_conflict;

  int total = 0;
  int bad   = 0;

  sap_alu_stage #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_in       (bus_in),
    .a_in         (a_in),
    .bi           (bi),
    .su           (su),
    .eo           (eo),
    .fi           (fi),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe),
    .b_reg        (b_reg),
    .cf           (cf),
    .zf           (zf),
    .of           (of),
    .bus_conflict (bus_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge; returns at the following falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bi = 0; su = 0; eo = 0; fi = 0;
  endtask

  task automatic load_b(input logic [7:0] v);
    idle();
    bi = 1; bus_in = v;
    tick();
    bi = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; bus_in = 8'hFF; bi = 1; a_in = 8'h00;
    tick(); tick();
    total++; if (b_reg !== 8'h00) begin bad++; $display("FAIL reset_b: got %h want 00", b_reg); end
    total++; if ({cf, zf, of} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {cf, zf, of}); end
    total++; if (bus_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict: got %b want 0", bus_conflict); end
    total++; if (bus_out !== 8'h00 || bus_oe !== 1'b0) begin bad++; $display("FAIL reset_bus: got %h/%b want 00/0", bus_out, bus_oe); end
    rst_n = 1;
    tick();
    total++; if (b_reg !== 8'hFF) begin bad++; $display("FAIL reset_release_load: got %h want FF", b_reg); end
    $display("reset: b_reg=%h flags=%b%b%b", b_reg, cf, zf, of);
  endtask

  task automatic test_add();
    load_b(8'h05);
    a_in = 8'h03; su = 0; eo = 1; fi = 1;
    #1;
    total++; if (bus_out !== 8'h08 || bus_oe !== 1'b1) begin bad++; $display("FAIL add_bus: got %h/%b want 08/1", bus_out, bus_oe); end
    tick();
    total++; if ({cf, zf, of} !== 3'b000) begin bad++; $display("FAIL add_flags: got %b want 000", {cf, zf, of}); end
    $display("add 03+05: bus=%h cf=%b zf=%b of=%b", bus_out, cf, zf, of);
  endtask

  task automatic test_add_wrap();
    load_b(8'h01);
    a_in = 8'hFF; su = 0; eo = 1; fi = 1;
    #1;
    total++; if (bus_out !== 8'h00) begin bad++; $display("FAIL wrap_bus: got %h want 00", bus_out); end
    tick();
    total++; if ({cf, zf, of} !== 3'b110) begin bad++; $display("FAIL wrap_flags: got %b want 110", {cf, zf, of}); end
    $display("add FF+01: cf=%b zf=%b of=%b", cf, zf, of);
  endtask

  task automatic test_sub();
    load_b(8'h10);
    a_in = 8'h10; su = 1; eo = 1; fi = 1;
    #1;
    total++; if (bus_out !== 8'h00) begin bad++; $display("FAIL sub_eq_bus: got %h want 00", bus_out); end
    tick();
    total++; if ({cf, zf, of} !== 3'b110) begin bad++; $display("FAIL sub_eq_flags: got %b want 110", {cf, zf, of}); end
    $display("sub 10-10: cf=%b zf=%b of=%b", cf, zf, of);
    load_b(8'h01);
    a_in = 8'h00; su = 1; eo = 1; fi = 1;
    #1;
    total++; if (bus_out !== 8'hFF) begin bad++; $display("FAIL sub_borrow_bus: got %h want FF", bus_out); end
    tick();
    total++; if ({cf, zf, of} !== 3'b000) begin bad++; $display("FAIL sub_borrow_flags: got %b want 000", {cf, zf, of}); end
    $display("sub 00-01: cf=%b zf=%b of=%b", cf, zf, of);
  endtask

  task automatic test_overflow();
    load_b(8'h01);
    a_in = 8'h7F; su = 0; eo = 1; fi = 1;
    #1;
    total++; if (bus_out !== 8'h80) begin bad++; $display("FAIL ovf_add_bus: got %h want 80", bus_out); end
    tick();
    total++; if ({cf, zf, of} !== 3'b001) begin bad++; $display("FAIL ovf_add_flags: got %b want 001", {cf, zf, of}); end
    $display("add 7F+01: cf=%b zf=%b of=%b", cf, zf, of);
    a_in = 8'h80; su = 1; eo = 1; fi = 1;
    #1;
    total++; if (bus_out !== 8'h7F) begin bad++; $display("FAIL ovf_sub_bus: got %h want 7F", bus_out); end
    tick();
    total++; if ({cf, zf, of} !== 3'b101) begin bad++; $display("FAIL ovf_sub_flags: got %b want 101", {cf, zf, of}); end
    $display("sub 80-01: cf=%b zf=%b of=%b", cf, zf, of);
  endtask

  task automatic test_flags_hold_and_preload();
    // fi low: flags keep 101 although sum changes.
    idle(); a_in = 8'h00; su = 0;
    tick();
    total++; if ({cf, zf, of} !== 3'b101) begin bad++; $display("FAIL flags_hold: got %b want 101", {cf, zf, of}); end
    // fi with bi: flags see old B (01), so 01+01 = 02 -> 000.
    a_in = 8'h01; su = 0; bi = 1; bus_in = 8'hFF; fi = 1;
    tick();
    total++; if ({cf, zf, of} !== 3'b000) begin bad++; $display("FAIL fi_with_bi_flags: got %b want 000", {cf, zf, of}); end
    total++; if (b_reg !== 8'hFF) begin bad++; $display("FAIL fi_with_bi_load: got %h want FF", b_reg); end
    idle(); eo = 1;
    #1;
    total++; if (bus_out !== 8'h00) begin bad++; $display("FAIL new_b_sum: got %h want 00", bus_out); end
    $display("fi+bi: flags=%b%b%b b_reg=%h", cf, zf, of, b_reg);
  endtask

  task automatic test_conflict_and_reset();
    idle();
    a_in = 8'hFF; su = 0; bi = 1; eo = 1; fi = 1; bus_in = 8'hAA;
    tick();
    total++; if (b_reg !== 8'hFF) begin bad++; $display("FAIL conflict_no_load: got %h want FF", b_reg); end
    total++; if (bus_conflict !== 1'b1) begin bad++; $display("FAIL conflict_set: got %b want 1", bus_conflict); end
    total++; if ({cf, zf, of} !== 3'b100) begin bad++; $display("FAIL conflict_flags: got %b want 100", {cf, zf, of}); end
    idle();
    tick();
    total++; if (bus_conflict !== 1'b1) begin bad++; $display("FAIL conflict_sticky: got %b want 1", bus_conflict); end
    // Partial-cycle reset pulse away from any edge.
    eo = 1;
    #2 rst_n = 0;
    #1;
    total++; if (b_reg !== 8'h00 || bus_conflict !== 1'b0 || {cf, zf, of} !== 3'b000) begin
      bad++; $display("FAIL midop_reset: got b=%h c=%b f=%b%b%b want 00/0/000", b_reg, bus_conflict, cf, zf, of);
    end
    total++; if (bus_out !== 8'hFF || bus_oe !== 1'b1) begin bad++; $display("FAIL reset_bus_eo: got %h/%b want FF/1", bus_out, bus_oe); end
    #1 rst_n = 1;
    @(negedge clk);
    load_b(8'h3C);
    total++; if (b_reg !== 8'h3C) begin bad++; $display("FAIL post_reset_load: got %h want 3C", b_reg); end
    $display("conflict/reset: b_reg=%h conflict=%b", b_reg, bus_conflict);
  endtask

  initial begin
    idle(); rst_n = 0; bus_in = 0; a_in = 0;
    test_reset();
    test_add();
    test_add_wrap();
    test_sub();
    test_overflow();
    test_flags_hold_and_preload();
    test_conflict_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
